// File: rtl/oclib_pkg.sv
// Shared types for the byte-channel command initiator.
// Holds the bidirectional byte bundle and the initiator state enum.
package oclib_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       ready;
  } bc_8b_bidi_s;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    RESP
  } bc_cmd_init_state_e;

endpackage

// File: rtl/oclib_bc_cmd_timer.sv
// Loadable up/down counter with enable and clear.
// Flags expiry when the count matches the supplied limit.
module oclib_bc_cmd_timer #(
  parameter int Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             enable,
  input  logic             count_up,
  input  logic [Width-1:0] limit,
  output logic             expired
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  // Clear beats load beats counting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable) begin
      if (count_up) count_d = count_q + Width'(1);
      else          count_d = count_q - Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expired = (count_q == limit);

endmodule

// File: rtl/oclib_bc_bidi_cmd_initiator.sv
// Serializes one command word LS byte first, then gathers a response word.
// Optional counters: OCLIB_BC_CMD_INITIATOR_STATS_EN.
module oclib_bc_bidi_cmd_initiator
  import oclib_pkg::*;
#(
  parameter int CmdWidth      = 32,
  parameter int RespWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  output bc_8b_bidi_s          bcOut,
  input  bc_8b_bidi_s          bcIn,
  input  logic [CmdWidth-1:0]  cmdData,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  output logic [RespWidth-1:0] respData,
  output logic                 respTimeout,
  output logic                 respValid,
  input  logic                 respReady,
  output logic                 dropPulse
`ifdef OCLIB_BC_CMD_INITIATOR_STATS_EN
  ,
  output logic [15:0]          statCmdCount,
  output logic [15:0]          statTimeoutCount
`endif
);

  localparam int CmdBytes  = CmdWidth / 8;
  localparam int RespBytes = RespWidth / 8;
  localparam int MaxBytes  = (CmdBytes > RespBytes) ? CmdBytes : RespBytes;
  localparam int CntW      = $clog2(MaxBytes + 1);
  localparam int TmrW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit TmoEn     = (TimeoutCycles > 0);

  bc_cmd_init_state_e state_q, state_d;
  logic                 alive_q;
  logic [CmdWidth-1:0]  cmd_q, cmd_d;
  logic [RespWidth-1:0] resp_q, resp_d;
  logic                 tmo_q, tmo_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 tmr_clr;
  logic                 tmr_exp;
  logic                 in_idle;
  logic                 cmd_accept;
  logic                 tmo_enter;

  oclib_bc_cmd_timer #(
    .Width(TmrW)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (tmr_clr),
    .load      (1'b0),
    .load_value('0),
    .enable    (state_q == WAIT),
    .count_up  (1'b1),
    .limit     (TmrW'(TimeoutCycles - 1)),
    .expired   (tmr_exp)
  );

  // Handshake outputs; alive_q keeps everything quiet until reset has released.
  always_comb begin
    in_idle     = (state_q == IDLE) && alive_q;
    cmdReady    = in_idle;
    bcOut.valid = (state_q == SEND);
    bcOut.data  = (state_q == SEND) ? cmd_q[7:0] : 8'h00;
    bcOut.ready = in_idle || (state_q == WAIT);
    respValid   = (state_q == RESP);
    respData    = resp_q;
    respTimeout = tmo_q;
    dropPulse   = in_idle && bcIn.valid;
  end

  // Next-state and datapath; a final byte beats a coincident timeout.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    resp_d     = resp_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    tmr_clr    = 1'b0;
    cmd_accept = 1'b0;
    tmo_enter  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmdValid && in_idle) begin
          cmd_accept = 1'b1;
          cmd_d      = cmdData;
          resp_d     = '0;
          tmo_d      = 1'b0;
          cnt_d      = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (bcIn.ready) begin
          cmd_d = cmd_q >> 8;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(CmdBytes - 1)) begin
            cnt_d   = '0;
            tmr_clr = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bcIn.valid) begin
          resp_d = resp_q >> 8;
          resp_d[RespWidth-1 -: 8] = bcIn.data;
          cnt_d = cnt_q + CntW'(1);
        end
        if (bcIn.valid && cnt_q == CntW'(RespBytes - 1)) begin
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (TmoEn && tmr_exp) begin
          tmo_enter = 1'b1;
          tmo_d     = 1'b1;
          resp_d    = '0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (respReady) state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      cmd_q   <= '0;
      resp_q  <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      cmd_q   <= cmd_d;
      resp_q  <= resp_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef OCLIB_BC_CMD_INITIATOR_STATS_EN
  logic [15:0] stat_cmd_q, stat_cmd_d;
  logic [15:0] stat_tmo_q, stat_tmo_d;

  // Saturating event counters.
  always_comb begin
    stat_cmd_d = stat_cmd_q;
    stat_tmo_d = stat_tmo_q;
    if (cmd_accept && stat_cmd_q != 16'hFFFF) stat_cmd_d = stat_cmd_q + 16'd1;
    if (tmo_enter && stat_tmo_q != 16'hFFFF) stat_tmo_d = stat_tmo_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_cmd_q <= '0;
      stat_tmo_q <= '0;
    end else begin
      stat_cmd_q <= stat_cmd_d;
      stat_tmo_q <= stat_tmo_d;
    end
  end

  assign statCmdCount     = stat_cmd_q;
  assign statTimeoutCount = stat_tmo_q;
`endif

endmodule

// File: tb/tb_oclib_bc_bidi_cmd_initiator.sv
// Randomized scoreboard bench for the byte-channel command initiator.
// Driver pushes expected bytes/responses; a negedge monitor pops and compares.
module tb_oclib_bc_bidi_cmd_initiator;
  import oclib_pkg::*;

  localparam int CW  = 32;
  localparam int RW  = 16;
  localparam int TO  = 8;
  localparam int CB  = CW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bc_8b_bidi_s    bc_out;
  bc_8b_bidi_s    bc_in;
  logic [CW-1:0]  cmd_data;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [RW-1:0]  resp_data;
  logic           resp_timeout;
  logic           resp_valid;
  logic           resp_ready;
  logic           drop_pulse;
`ifdef OCLIB_BC_CMD_INITIATOR_STATS_EN
  logic [15:0]    stat_cmd;
  logic [15:0]    stat_tmo;
`endif

  oclib_bc_bidi_cmd_initiator #(
    .CmdWidth(CW),
    .RespWidth(RW),
    .TimeoutCycles(TO)
  ) dut (
    .clock      (clk),
    .reset      (rst_n),
    .bcOut      (bc_out),
    .bcIn       (bc_in),
    .cmdData    (cmd_data),
    .cmdValid   (cmd_valid),
    .cmdReady   (cmd_ready),
    .respData   (resp_data),
    .respTimeout(resp_timeout),
    .respValid  (resp_valid),
    .respReady  (resp_ready),
    .dropPulse  (drop_pulse)
`ifdef OCLIB_BC_CMD_INITIATOR_STATS_EN
    ,
    .statCmdCount    (stat_cmd),
    .statTimeoutCount(stat_tmo)
`endif
  );

  typedef struct {
    logic [RW-1:0] data;
    logic          tmo;
  } resp_t;

  logic [7:0] exp_bytes[$];
  resp_t      exp_resp[$];
  int n_checks = 0;
  int n_fails = 0;
  int drops_seen = 0;
  int drops_exp = 0;
  int n_cmds = 0;
  int n_tmos = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: scoreboard pops plus hold-stability checks.
  initial begin
    bit         stall_prev = 0;
    logic [7:0] stall_data = '0;
    bit         rstall_prev = 0;
    resp_t      rhold;
    resp_t      e;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev  = 0;
        rstall_prev = 0;
      end else begin
        if (stall_prev) begin
          check("byte_hold_valid", bc_out.valid, 1);
          check("byte_hold_data", bc_out.data, stall_data);
        end
        if (bc_out.valid && bc_in.ready) begin
          if (exp_bytes.size() == 0) fail_now("cmd_byte_unexpected");
          else begin
            eb = exp_bytes.pop_front();
            check("cmd_byte", bc_out.data, eb);
          end
        end
        stall_prev = bc_out.valid && !bc_in.ready;
        stall_data = bc_out.data;
        if (rstall_prev) begin
          check("resp_hold_valid", resp_valid, 1);
          check("resp_hold_data", resp_data, rhold.data);
          check("resp_hold_tmo", resp_timeout, rhold.tmo);
        end
        if (resp_valid && resp_ready) begin
          if (exp_resp.size() == 0) fail_now("resp_unexpected");
          else begin
            e = exp_resp.pop_front();
            check("resp_data", resp_data, e.data);
            check("resp_timeout", resp_timeout, e.tmo);
          end
        end
        rstall_prev = resp_valid && !resp_ready;
        rhold.data  = resp_data;
        rhold.tmo   = resp_timeout;
        if (drop_pulse) drops_seen++;
      end
    end
  end

  task automatic check_all_zero(string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_bc_out"}, bc_out, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_timeout"}, resp_timeout, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_drop_pulse"}, drop_pulse, 0);
  endtask

  // One command. mode: 0 ready held, 1 toggling, 2 random.
  // t0/t1: WAIT-cycle index of response bytes; >= TO means never sent.
  task automatic run_txn(input logic [CW-1:0] cmd, input int mode,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input int t0, input int t1, input int ack_dly,
                         input bit rst_mid);
    int    w;
    int    cyc;
    int    sent;
    int    idx;
    bit    xfer;
    bit    ok;
    resp_t r;
    logic [CW-1:0] c;
    bc_in.ready = 1'b1;
    bc_in.valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!cmd_ready) begin
      if (++w > 50) begin
        fail_now("cmd_ready_timeout");
        return;
      end
      @(negedge clk);
    end
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    c = cmd;
    for (int i = 0; i < CB; i++) begin
      exp_bytes.push_back(c[7:0]);
      c = c >> 8;
    end
    n_cmds++;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    sent = 0;
    cyc  = 0;
    while (sent < CB) begin
      @(negedge clk);
      xfer = bc_out.valid && bc_in.ready;
      if (cyc == 0) check("first_byte_valid", bc_out.valid, 1);
      @(posedge clk);
      #1;
      cyc++;
      if (xfer) sent++;
      if (cyc > 100) begin
        fail_now("send_timeout");
        return;
      end
      case (mode)
        0: bc_in.ready = 1'b1;
        1: bc_in.ready = (cyc % 2 == 0);
        default: bc_in.ready = 1'($urandom_range(0, 1));
      endcase
    end
    if (mode == 0) check("send_cycles", cyc, CB);
    ok     = (t1 <= TO - 1);
    r.tmo  = !ok;
    r.data = ok ? {b1, b0} : '0;
    if (!ok) n_tmos++;
    exp_resp.push_back(r);
    idx = 0;
    forever begin
      if (rst_mid && idx == 3) begin
        rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        bc_in = '0;
        void'(exp_resp.pop_back());
        if (!ok) n_tmos--;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);
        return;
      end
      bc_in.valid = 1'b0;
      bc_in.data  = 8'($urandom);
      if (idx == t0 && t0 < TO) begin
        bc_in.valid = 1'b1;
        bc_in.data  = b0;
      end
      if (idx == t1 && t1 < TO) begin
        bc_in.valid = 1'b1;
        bc_in.data  = b1;
      end
      @(negedge clk);
      if (idx == 0) check("wait_bc_ready", bc_out.ready, 1);
      if (resp_valid) break;
      @(posedge clk);
      #1;
      idx++;
      if (idx > 40) begin
        fail_now("resp_wait_timeout");
        return;
      end
    end
    check("resp_latency", idx, ok ? t1 + 1 : TO);
    check("resp_bc_ready_low", bc_out.ready, 0);
    @(posedge clk);
    #1 bc_in.valid = 1'b0;
    repeat (ack_dly) begin
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_resp", cmd_ready, 1);
    if (!ok) begin
      @(posedge clk);
      #1;
      bc_in.valid = 1'b1;
      bc_in.data  = 8'($urandom);
      drops_exp++;
      @(negedge clk);
      check("late_drop_pulse", drop_pulse, 1);
      @(posedge clk);
      #1 bc_in.valid = 1'b0;
      @(negedge clk);
      check("drop_pulse_width", drop_pulse, 0);
    end
  endtask

  // Stimulus: directed plan items then randomized commands.
  initial begin
    int t0;
    bc_in      = '0;
    cmd_data   = '0;
    cmd_valid  = 1'b0;
    resp_ready = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_txn(32'h44332211, 0, 8'hAA, 8'hBB, 1, 2, 5, 0);
    run_txn(32'($urandom), 1, 8'h5A, 8'hC3, 0, 1, 2, 0);
    run_txn(32'($urandom), 0, 8'h12, 8'h34, 2, 99, 1, 0);
    run_txn(32'($urandom), 0, 8'h9E, 8'h7F, 3, 7, 0, 0);
    run_txn(32'($urandom), 2, 8'h01, 8'h02, 0, 8, 3, 0);
    run_txn(32'($urandom), 0, 8'h66, 8'h77, 1, 99, 0, 1);
    run_txn(32'hDEADBEEF, 0, 8'hEF, 8'hBE, 4, 5, 0, 0);
    for (int i = 0; i < 30; i++) begin
      t0 = $urandom_range(0, 9);
      run_txn(32'($urandom), $urandom_range(0, 2),
              8'($urandom), 8'($urandom),
              t0, t0 + $urandom_range(1, 4),
              $urandom_range(0, 5), 0);
    end
    repeat (3) @(negedge clk);
    check("bytes_left", exp_bytes.size(), 0);
    check("resps_left", exp_resp.size(), 0);
    check("drop_count", drops_seen, drops_exp);
`ifdef OCLIB_BC_CMD_INITIATOR_STATS_EN
    check("stat_cmd", stat_cmd, n_cmds - 1);
    check("stat_tmo", stat_tmo, n_tmos);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
